// File: rtl/dsp48a1_ctrl_pkg.sv
// Shared constants and state encoding for the DSP48A1 MAC sequencer.
// OPMODE values: X mux in [1:0], Z mux in [3:2].
package dsp48a1_ctrl_pkg;

  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;
  localparam logic [7:0] OPM_IDLE  = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/tag_delay.sv
// DEPTH x WIDTH shift register with sync reset.
// DEPTH=0 degenerates to a wire.
module tag_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_sr
    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
      if (rst) begin
        sr <= '0;
      end else begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++)
          sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/dsp48a1_mac_ctrl.sv
// Length-N multiply-accumulate sequencer for one DSP48A1 slice.
// Tags ride a delay line so each OPMODE meets its product.
module dsp48a1_mac_ctrl
  import dsp48a1_ctrl_pkg::*;
#(
  parameter int LEN_W     = 10,
  parameter int IN_STAGES = 2,
  parameter int MREG      = 1,
  parameter int PREG      = 1,
  parameter int OPMODEREG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      a_in,
  input  logic [17:0]      b_in,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  input  logic [47:0]      dsp_p,
  output logic [47:0]      result,
  output logic             result_valid,
  output logic             busy
);

  localparam int OPM_DLY = IN_STAGES + MREG - OPMODEREG;
  localparam int PIPE    = IN_STAGES + MREG + PREG;
  localparam int CNT_W   = (PIPE < 2) ? 1 : $clog2(PIPE);

  state_t           state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic             first, first_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [47:0]      res_n;
  logic [7:0]       tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      rem    <= '0;
      first  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state  <= state_n;
      rem    <= rem_n;
      first  <= first_n;
      cnt    <= cnt_n;
      result <= res_n;
    end
  end

  always_comb begin
    state_n  = state;
    rem_n    = rem;
    first_n  = first;
    cnt_n    = cnt;
    res_n    = result;
    in_ready = 1'b0;
    dsp_ce   = 1'b0;
    dsp_a    = '0;
    dsp_b    = '0;
    tag      = OPM_IDLE;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            res_n   = '0;
            state_n = S_DONE;
          end else begin
            rem_n   = len;
            first_n = 1'b1;
            state_n = S_ACC;
          end
        end
      end
      S_ACC: begin
        in_ready = 1'b1;
        dsp_ce   = 1'b1;
        tag      = OPM_HOLD;
        if (in_valid) begin
          dsp_a   = a_in;
          dsp_b   = b_in;
          tag     = first ? OPM_FIRST : OPM_ACC;
          first_n = 1'b0;
          rem_n   = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            cnt_n   = '0;
            state_n = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        dsp_ce = 1'b1;
        tag    = OPM_HOLD;
        // last product has settled in P by the final drain cycle
        if (cnt == CNT_W'(PIPE - 1)) begin
          res_n   = dsp_p;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign result_valid = (state == S_DONE);
  assign busy         = (state != S_IDLE);

  tag_delay #(
    .DEPTH(OPM_DLY),
    .WIDTH(8)
  ) u_opm_dly (
    .clk (clk),
    .rst (rst),
    .din (tag),
    .dout(dsp_opmode)
  );

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// Bench for dsp48a1_mac_ctrl: slice model on dsp_p,
// dot-product and tag-schedule reference per job.
module tb_dsp48a1_mac_ctrl;
  import dsp48a1_ctrl_pkg::*;

  localparam int LEN_W     = 10;
  localparam int IN_STAGES = 2;
  localparam int MREG      = 1;
  localparam int PREG      = 1;
  localparam int OPMODEREG = 1;
  localparam int OPM_DLY   = IN_STAGES + MREG - OPMODEREG;
  localparam int PIPE      = IN_STAGES + MREG + PREG;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [17:0]      a_in = '0;
  logic [17:0]      b_in = '0;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce;
  logic [47:0]      dsp_p;
  logic [47:0]      result;
  logic             result_valid;
  logic             busy;

  int nvec = 0;
  int nerr = 0;

  logic signed [17:0] A [32];
  logic signed [17:0] B [32];
  int                 gap [32];

  always #5 clk = ~clk;

  dsp48a1_mac_ctrl #(
    .LEN_W(LEN_W), .IN_STAGES(IN_STAGES), .MREG(MREG),
    .PREG(PREG), .OPMODEREG(OPMODEREG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in),
    .dsp_a(dsp_a), .dsp_b(dsp_b),
    .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_p(dsp_p), .result(result),
    .result_valid(result_valid), .busy(busy)
  );

  // Behavioural DSP48A1: A0/A1, B0/B1, MREG, OPMODEREG, PREG
  logic signed [17:0] a1 = '0, a2 = '0, b1 = '0, b2 = '0;
  logic [47:0]        m = '0, p = '0;
  logic [7:0]         opr = '0;
  assign dsp_p = p;

  always @(posedge clk) begin
    if (dsp_ce) begin
      a1  <= dsp_a;
      a2  <= a1;
      b1  <= dsp_b;
      b2  <= b1;
      m   <= 48'(longint'(a2) * longint'(b2));
      opr <= dsp_opmode;
      p   <= ((opr[3:2] == 2'b10) ? p : 48'd0) +
             ((opr[1:0] == 2'b01) ? m : 48'd0);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One job: gap[i] bubbles precede pair i; mid>0 pulses a stray start.
  task automatic run_job(input int n, input int mid);
    longint     acc;
    logic [7:0] hist [$];
    logic [7:0] t;
    int         i, bub, last;
    bit         done, xfer, accp, drn;
    acc  = 0;
    i    = 0;
    last = 0;
    done = 0;
    for (int k = 0; k < n; k++)
      acc += longint'(A[k]) * longint'(B[k]);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ready", in_ready, 0);
    start    = 1'b1;
    len      = LEN_W'(n);
    in_valid = 1'b0;
    repeat (OPM_DLY) hist.push_back(OPM_IDLE);
    bub = (n > 0) ? gap[0] : 0;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge clk);
      start = (cyc == mid);
      len   = start ? LEN_W'(5) : '0;
      accp  = (i < n);
      drn   = (n > 0) && (i == n) && (cyc <= last + PIPE);
      xfer  = accp && (bub == 0);
      in_valid = accp ? xfer : 1'($urandom_range(0, 1));
      a_in  = xfer ? A[i] : 18'($urandom);
      b_in  = xfer ? B[i] : 18'($urandom);
      #1;
      if (!accp)      t = drn ? OPM_HOLD : OPM_IDLE;
      else if (!xfer) t = OPM_HOLD;
      else            t = (i == 0) ? OPM_FIRST : OPM_ACC;
      hist.push_back(t);
      chk("in_ready", in_ready, accp);
      chk("dsp_ce", dsp_ce, accp || drn);
      chk("dsp_a", dsp_a, xfer ? $unsigned(A[i]) : 18'd0);
      chk("dsp_b", dsp_b, xfer ? $unsigned(B[i]) : 18'd0);
      chk("dsp_opmode", dsp_opmode, hist[hist.size()-1-OPM_DLY]);
      chk("busy", busy, 1);
      if (result_valid) begin
        done = 1;
        chk("rv_cycle", cyc, (n > 0) ? last + PIPE + 1 : 1);
        chk("result", result, {16'd0, acc[47:0]});
      end
      if (xfer) begin
        i++;
        last = cyc;
        bub  = (i < n) ? gap[i] : 0;
      end else if (accp) begin
        bub--;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (!done) chk("timeout", 0, 1);
  endtask

  task automatic clr_gaps();
    for (int k = 0; k < 32; k++) gap[k] = 0;
  endtask

  initial begin
    clr_gaps();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dsp_a", dsp_a, 0);
    chk("rst_dsp_b", dsp_b, 0);
    chk("rst_opmode", dsp_opmode, 0);
    chk("rst_ce", dsp_ce, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      A[k] = 18'(k + 1);
      B[k] = 18'(k + 5);
    end
    run_job(4, -1);
    chk("dot70", result, 48'd70);

    gap[2] = 2;
    run_job(4, -1);
    chk("dot70_bubble", result, 48'd70);
    clr_gaps();

    A[0] = -18'sd3;
    B[0] = 18'sd7;
    run_job(1, -1);
    chk("neg21", result, 48'hFFFF_FFFF_FFEB);

    run_job(0, -1);
    chk("len0", result, 0);

    A[0] = 18'sd2; B[0] = 18'sd3;
    A[1] = 18'sd4; B[1] = 18'sd5;
    run_job(1, 1);
    chk("b2b_first", result, 48'd6);
    A[0] = 18'sd4; B[0] = 18'sd5;
    run_job(1, -1);
    chk("b2b_second", result, 48'd20);

    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(8);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    a_in     = 18'd1;
    b_in     = 18'd1;
    repeat (3) @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ce", dsp_ce, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_opmode", dsp_opmode, 0);
    chk("mid_rst_rv", result_valid, 0);
    chk("mid_rst_result", result, 0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_rv", result_valid, 0);
      chk("abort_busy", busy, 0);
    end
    A[0] = 18'sd1; B[0] = 18'sd1;
    A[1] = 18'sd1; B[1] = 18'sd1;
    run_job(2, -1);
    chk("after_abort", result, 48'd2);

    for (int j = 0; j < 10; j++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        A[k]   = 18'($urandom);
        B[k]   = 18'($urandom);
        gap[k] = $urandom_range(0, 2);
      end
      run_job(n, ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : -1);
    end
    clr_gaps();

    @(negedge clk);
    chk("final_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dsp48a1_mac_ctrl.md
# dsp48a1_mac_ctrl

Sequencer that runs a length-N multiply-accumulate on one DSP48A1 slice. It accepts an operand stream through a valid/ready handshake and drives the slice's A/B inputs, OPMODE and clock enables. It tracks the slice's pipeline depth so the first product clears the accumulator and input bubbles hold it. It then captures P and returns the 48-bit dot product with a one-cycle result_valid pulse. It sits between a stream source (filter/dot-product engine) and the DSP48A1 top.

## Interface
Parameters:
- LEN_W, 10, width of the length field.
- IN_STAGES, 2, total A/B input register stages configured in the slice (A0REG+A1REG; B path equal).
- MREG, 1, multiplier output register present (0/1).
- PREG, 1, P register present (0/1).
- OPMODEREG, 1, OPMODE register present (0/1). Legal only when IN_STAGES+MREG >= OPMODEREG.

Ports:
- clk, input, 1, single clock, all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a job; sampled only in IDLE.
- len, input, LEN_W, number of operand pairs; sampled with start.
- in_valid, input, 1, operand pair available.
- in_ready, output, 1, controller accepts a pair this cycle.
- a_in, input, 18, signed operand A.
- b_in, input, 18, signed operand B.
- dsp_a, output, 18, to slice A port.
- dsp_b, output, 18, to slice B port.
- dsp_opmode, output, 8, to slice OPMODE.
- dsp_ce, output, 1, common CEA/CEB/CEM/CEP/CEOPMODE enable.
- dsp_p, input, 48, slice P output.
- result, output, 48, captured accumulation.
- result_valid, output, 1, one-cycle pulse with result.
- busy, output, 1, high from start acceptance until the result_valid cycle, inclusive.

## Operation
- FSM states are IDLE, ACC, DRAIN and DONE.
- IDLE with start=1 and len>0: latch len into the remaining counter, set the first flag, go to ACC, busy=1.
- IDLE with start=1 and len=0: go directly to DONE. result=0. No DSP activity, dsp_ce stays 0.
- start while not IDLE is ignored.
- ACC: in_ready=1.
  - A transfer happens when in_valid&&in_ready. The pair drives dsp_a/dsp_b combinationally from a_in/b_in.
  - Each transfer decrements the remaining counter and clears the first flag.
  - Moving to DRAIN happens in the cycle after the last transfer. in_ready is 0 in DRAIN.
- Every ACC cycle injects a tag into the tag delay line:
  - first-transfer slot: 8'h01, X=M, Z=0, clears the accumulator.
  - later transfers: 8'h09, X=M, Z=P.
  - bubble (no transfer): 8'h08, X=0, Z=P, holds P; dsp_a/dsp_b forced to 0.
- All pre-adder, carry-in and post-subtract OPMODE bits are 0.
- dsp_opmode is the tag delayed by OPM_DLY = IN_STAGES+MREG-OPMODEREG cycles. The tag thus meets its product at the post-adder.
- DRAIN keeps injecting 8'h08 and counts PIPE = IN_STAGES+MREG+PREG cycles. It then samples dsp_p into result and goes to DONE.
- DONE: result_valid=1 for one cycle, then IDLE.
- dsp_ce=1 in ACC and DRAIN, otherwise 0.
- Arithmetic: accumulation wraps modulo 2^48 in the slice. No overflow flag.
- Reset values: FSM state IDLE. The following outputs are all 0: in_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, result, result_valid and busy.
- Reset mid-job abandons the job. The tag delay line is cleared to 8'h00.

## Timing
- Start accepted at edge T0: ACC from T0+1.
- With the last transfer at edge Tl: DRAIN occupies Tl+1 .. Tl+PIPE. result is registered at edge Tl+PIPE+1 and result_valid is high in that cycle.
- Defaults (PIPE=4), len=N with no bubbles: result_valid at T0+N+5.
- len=0: result_valid at T0+1.
- With OPM_DLY=0 the tag drives dsp_opmode directly. The delay line degenerates to wires.
- A new start is accepted in the cycle after result_valid. The first tag clears P, so there is no carry-over between jobs.

## Structure
- Shared package dsp48a1_ctrl_pkg holds:
  - OPMODE constants OPM_FIRST=8'h01, OPM_ACC=8'h09, OPM_HOLD=8'h08, OPM_IDLE=8'h00;
  - the state enum.
- Sub-module tag_delay: a parameterised DEPTH x WIDTH shift register with sync reset and a DEPTH=0 passthrough. It is used for OPMODE alignment.

## Test plan
- len=4, A={1,2,3,4}, B={5,6,7,8}, in_valid always 1 -> result=70, result_valid at T0+9 with default parameters.
- Same job with in_valid low for 2 cycles between the 2nd and 3rd pair -> result=70, result_valid delayed by exactly 2 cycles, dsp_opmode=8'h08 in the bubble slots.
- len=1, A=-3, B=7 -> result=48'hFFFF_FFFF_FFEB (-21).
- len=0 -> result=0 and result_valid one cycle after start; dsp_ce never asserted.
- Back-to-back jobs: {2x3} then {4x5} with start the cycle after result_valid -> results 6 then 20. A start pulsed during the first job is ignored.
- Assert rst during ACC of a len=8 job, then start len=2 {1x1,1x1} -> no result_valid for the aborted job; second result=2.
